// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU ops, opcodes/functs
// and the packed control word driven onto the datapath.
package multicycle_control_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R    = 4'd7;
    localparam logic [3:0] S_WB_R      = 4'd8;
    localparam logic [3:0] S_EXEC_I    = 4'd9;
    localparam logic [3:0] S_WB_I      = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;
    localparam logic [3:0] S_FAULT     = 4'd13;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branchne;
        logic [1:0] pcsource;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] alu_op;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       retired;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct to ALU operation map; legal_c drops for any funct the datapath cannot execute.
module alu_op_decode
    import multicycle_control_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] alu_op_c,
    output logic               legal_c
);

    always_comb begin
        alu_op_c = '0;
        legal_c  = 1'b1;
        case (funct)
            FN_ADD, FN_ADDU: alu_op_c = ALUOP_W'(ALU_ADD);
            FN_SUB, FN_SUBU: alu_op_c = ALUOP_W'(ALU_SUB);
            FN_AND:          alu_op_c = ALUOP_W'(ALU_AND);
            FN_OR:           alu_op_c = ALUOP_W'(ALU_OR);
            FN_SLT:          alu_op_c = ALUOP_W'(ALU_SLT);
            FN_SLTU:         alu_op_c = ALUOP_W'(ALU_SLTU);
            default:         legal_c  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller with variable-latency memory handshake,
// optional wait timeout, optional bne and a sticky fault state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter bit          ENABLE_BNE  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic [1:0]         PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               retired,
    output logic               fault,
    output logic [3:0]         state_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         opcode, funct;
    logic [2:0]         r_op;
    logic               r_legal;
    logic               timeout_c;
    ctrl_t              c;

    assign opcode    = inst[31:26];
    assign funct     = inst[5:0];
    assign timeout_c = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

    alu_op_decode #(.ALUOP_W(3)) u_alu_op_decode (
        .funct    (funct),
        .alu_op_c (r_op),
        .legal_c  (r_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Wait counter restarts on every state change, so each memory access gets a full budget.
    always_ff @(posedge clk) begin
        if (rst)                                          cnt_q <= '0;
        else if (state_d != state_q)                      cnt_q <= '0;
        else if ((MEM_TIMEOUT != 0) && c.mem_req && !mem_ready) cnt_q <= cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        c       = '0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = 2'b01;
                c.alu_op  = ALU_ADD;
                c.irwrite = mem_ready;
                c.pcwrite = mem_ready;
                if (mem_ready)      state_d = S_DECODE;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                c.extop   = 1'b1;
                c.alu_op  = ALU_ADD;
                if (inst == 32'h0) begin
                    c.retired = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:     state_d = r_legal ? S_EXEC_R : S_FAULT;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_ADDI, OP_ORI: state_d = S_EXEC_I;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_BNE:       state_d = ENABLE_BNE ? S_BRANCH : S_FAULT;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FAULT;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.extop   = 1'b1;
                c.alu_op  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                if (mem_ready)      state_d = S_MEM_WB;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_MEM_WB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.retired  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
                c.retired = mem_ready;
                if (mem_ready)      state_d = S_FETCH;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_EXEC_R: begin
                c.alusrca = 1'b1;
                c.alu_op  = r_op;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.retired  = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.extop   = (opcode == OP_ADDI);
                c.alu_op  = (opcode == OP_ADDI) ? ALU_ADD : ALU_OR;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                c.regwrite = 1'b1;
                c.retired  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alu_op      = ALU_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.branchne    = (opcode == OP_BNE);
                c.retired     = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
                c.retired  = 1'b1;
                state_d    = S_FETCH;
            end
            S_FAULT: c.fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    assign mem_req     = c.mem_req;
    assign mem_we      = c.mem_we;
    assign IorD        = c.iord;
    assign IRWrite     = c.irwrite;
    assign PCWrite     = c.pcwrite;
    assign PCWriteCond = c.pcwritecond;
    assign BranchNe    = c.branchne;
    assign PCSource    = c.pcsource;
    assign ALUSrcA     = c.alusrca;
    assign ALUSrcB     = c.alusrcb;
    assign ExtOp       = c.extop;
    assign alu_op      = ALUOP_W'(c.alu_op);
    assign RegDst      = c.regdst;
    assign MemtoReg    = c.memtoreg;
    assign RegWrite    = c.regwrite;
    assign retired     = c.retired;
    assign fault       = c.fault;
    assign state_o     = state_q;

endmodule
